// File: rtl/stream_demux32_pkg.sv
// Shared definitions for the stream_demux32 slice: word width, port-select
// encodings and transfer-counter width.
package stream_demux32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic SEL_PORT_A = 1'b0;
    localparam logic SEL_PORT_B = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/demux_slot.sv
// Small per-port FIFO: push/full on the write side, valid/ready/data on the
// read side. The head word is always driven from storage, never from push_data.
module demux_slot
    import stream_demux32_pkg::*;
#(
    parameter int DEPTH_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [OCC_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign valid   = (count != '0);
    assign data    = mem[rd_ptr];

    // A full slot refuses a push even if it also pops this cycle.
    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset so the head word reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux32.sv
// Registered 1-to-2 stream demultiplexer with a small buffer per output.
// Define STREAM_DEMUX32_CNT_EN to add saturating per-port transfer counters.
module stream_demux32
    import stream_demux32_pkg::*;
#(
    parameter int DEPTH_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready
`ifdef STREAM_DEMUX32_CNT_EN
    ,
    output logic [CNT_W-1:0]  a_count,
    output logic [CNT_W-1:0]  b_count
`endif
);

    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;

    // Readiness depends only on the addressed slot's fill state, never on consumer ready.
    assign in_ready = (in_sel == SEL_PORT_B) ? !b_full : !a_full;
    assign a_push   = in_valid && in_ready && (in_sel == SEL_PORT_A);
    assign b_push   = in_valid && in_ready && (in_sel == SEL_PORT_B);

    demux_slot #(.DEPTH_LOG2(DEPTH_LOG2)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (in_data),
        .full      (a_full),
        .valid     (a_valid),
        .data      (a_data),
        .ready     (a_ready)
    );

    demux_slot #(.DEPTH_LOG2(DEPTH_LOG2)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (in_data),
        .full      (b_full),
        .valid     (b_valid),
        .data      (b_data),
        .ready     (b_ready)
    );

`ifdef STREAM_DEMUX32_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            if (a_valid && a_ready && (a_count != CNT_MAX)) begin
                a_count <= a_count + CNT_W'(1);
            end
            if (b_valid && b_ready && (b_count != CNT_MAX)) begin
                b_count <= b_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux32.sv
// Scoreboard bench for stream_demux32: accepted words are queued per port at
// the handshake and compared in order when the port hands them out.
module tb_stream_demux32;
    import stream_demux32_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
`ifdef STREAM_DEMUX32_CNT_EN
    logic [CNT_W-1:0]  a_count;
    logic [CNT_W-1:0]  b_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] exp_a[$];
    logic [DATA_W-1:0] exp_b[$];

    stream_demux32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef STREAM_DEMUX32_CNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    always #5 clk = ~clk;

    // Sampling on the falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) begin
                vectors++;
                if (exp_a.size() == 0) begin
                    miscompares++;
                    $display("FAIL a_unexpected_word got=%08h expected=<none>", a_data);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_a.pop_front();
                    if (a_data !== e) begin
                        miscompares++;
                        $display("FAIL a_data got=%08h expected=%08h", a_data, e);
                    end
                end
            end
            if (b_valid && b_ready) begin
                vectors++;
                if (exp_b.size() == 0) begin
                    miscompares++;
                    $display("FAIL b_unexpected_word got=%08h expected=<none>", b_data);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_b.pop_front();
                    if (b_data !== e) begin
                        miscompares++;
                        $display("FAIL b_data got=%08h expected=%08h", b_data, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (in_sel == SEL_PORT_A) exp_a.push_back(in_data);
                else                      exp_b.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic s, input logic v);
        in_data  = d;
        in_sel   = s;
        in_valid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive('0, SEL_PORT_A, 1'b0);
        a_ready = 1'b0;
        b_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({a_valid, b_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid got=%b expected=00", {a_valid, b_valid});
        end
        vectors++;
        if (a_data !== '0 || b_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data got=%08h/%08h expected=0/0", a_data, b_data);
        end
        in_sel = SEL_PORT_B;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready_b got=%b expected=1", in_ready);
        end
        in_sel = SEL_PORT_A;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready_a got=%b expected=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream_a();
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            logic [DATA_W-1:0] w;
            w = 32'h11111111 * i;
            drive(w, SEL_PORT_A, 1'b1);
            tick();
            vectors++;
            if (a_valid !== 1'b1 || a_data !== w || b_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_a_latency got=%b/%08h/%b expected=1/%08h/0",
                         a_valid, a_data, b_valid, w);
            end
        end
        drive('0, SEL_PORT_A, 1'b0);
        tick();
        vectors++;
        if (a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_a_drained got=%b expected=0", a_valid);
        end
    endtask

    task automatic test_alternate();
        logic [DATA_W-1:0] words [4];
        words = '{32'hA0000000, 32'hB0000000, 32'hA0000001, 32'hB0000001};
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(words[i], logic'(i % 2), 1'b1);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL alternate_in_ready[%0d] got=%b expected=1", i, in_ready);
            end
            tick();
        end
        drive('0, SEL_PORT_A, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_back_pressure();
        a_ready = 1'b1;
        b_ready = 1'b0;
        drive(32'hC0000001, SEL_PORT_B, 1'b1);
        tick();
        drive(32'hC0000002, SEL_PORT_B, 1'b1);
        tick();
        drive(32'hC0000003, SEL_PORT_B, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_in_ready got=%b expected=0", in_ready);
        end
        tick();
        vectors++;
        if (b_valid !== 1'b1 || b_data !== 32'hC0000001 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_head_stable got=%b/%08h/%b expected=1/c0000001/0",
                     b_valid, b_data, in_ready);
        end
        drive(32'h00000005, SEL_PORT_A, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_other_port_ready got=%b expected=1", in_ready);
        end
        tick();
        // Full B, consumer ready, producer still targeting B: pop only this cycle.
        drive(32'hC0000003, SEL_PORT_B, 1'b1);
        b_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full_pop_in_ready got=%b expected=0", in_ready);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || b_data !== 32'hC0000002) begin
            miscompares++;
            $display("FAIL bp_after_pop got=%b/%08h expected=1/c0000002", in_ready, b_data);
        end
        tick();
        drive('0, SEL_PORT_A, 1'b0);
        for (int i = 0; i < 10 && (a_valid || b_valid); i++) tick();
        vectors++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain_timeout got=%b/%b expected=0/0", a_valid, b_valid);
        end
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(32'hDEAD0001, SEL_PORT_A, 1'b1);
        tick();
        drive(32'hDEAD0002, SEL_PORT_A, 1'b1);
        tick();
        drive('0, SEL_PORT_A, 1'b0);
        #1;
        vectors++;
        if (a_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_preload got=%b/%b expected=1/0", a_valid, in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_async got=%b/%b expected=0/1", a_valid, in_ready);
        end
        exp_a.delete();
        exp_b.delete();
        a_ready = 1'b1;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (a_valid !== 1'b0 || a_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_stale got=%b/%08h expected=0/0", a_valid, a_data);
        end
        drive(32'h00000077, SEL_PORT_A, 1'b1);
        tick();
        drive('0, SEL_PORT_A, 1'b0);
        tick();
    endtask

`ifdef STREAM_DEMUX32_CNT_EN
    task automatic test_counters();
        a_ready = 1'b1;
        b_ready = 1'b1;
        // Reset clears counters and the slots before counting from zero.
        rst_n = 1'b0;
        exp_a.delete();
        exp_b.delete();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(32'hE0000000 + i, (i < 5) ? SEL_PORT_A : SEL_PORT_B, 1'b1);
            tick();
        end
        drive('0, SEL_PORT_A, 1'b0);
        tick();
        tick();
        vectors++;
        if (a_count !== 16'd5 || b_count !== 16'd3) begin
            miscompares++;
            $display("FAIL counters got=%0d/%0d expected=5/3", a_count, b_count);
        end
        force dut.a_count = 16'hFFFE;
        #1;
        release dut.a_count;
        for (int i = 0; i < 2; i++) begin
            drive(32'hF0000000 + i, SEL_PORT_A, 1'b1);
            tick();
        end
        drive('0, SEL_PORT_A, 1'b0);
        tick();
        tick();
        vectors++;
        if (a_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL counter_saturate got=%04h expected=ffff", a_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream_a();
        test_alternate();
        test_back_pressure();
        test_reset_mid();
`ifdef STREAM_DEMUX32_CNT_EN
        test_counters();
`endif
        vectors++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            miscompares++;
            $display("FAIL words_outstanding got=%0d/%0d expected=0/0", exp_a.size(), exp_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
